// File: rtl/dff_chain_ctrl.sv
// Serial loader for a Q-to-D chain of CHAIN_LEN flops: words in over valid/ready, bits out LSB-first.
// Define DFF_CHAIN_READBACK_EN to add SDI/RDATA/RVALID capture of the chain's previous contents.
module dff_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [WORD_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              SDO,
  output logic              SEN,
  output logic              UPD,
  output logic              BUSY,
  output logic              DONE
`ifdef DFF_CHAIN_READBACK_EN
  ,
  input  logic                 SDI,
  output logic [CHAIN_LEN-1:0] RDATA,
  output logic                 RVALID
`endif
);

  localparam int unsigned BW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WBW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_UPDATE,
    ST_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BW-1:0]     bits_sent_q, bits_sent_d;
  logic [WBW-1:0]    word_bit_q, word_bit_d;
  logic [WBW-1:0]    word_len_q, word_len_d;
  logic [31:0]       remaining;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      bits_sent_q <= '0;
      word_bit_q  <= '0;
      word_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      bits_sent_q <= bits_sent_d;
      word_bit_q  <= word_bit_d;
      word_len_q  <= word_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    bits_sent_d = bits_sent_q;
    word_bit_d  = word_bit_q;
    word_len_d  = word_len_q;
    remaining   = 32'(CHAIN_LEN) - 32'(bits_sent_q);
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_LOAD;
          bits_sent_d = '0;
          word_bit_d  = '0;
          word_len_d  = '0;
        end
      end
      ST_LOAD: begin
        if (WVALID) begin
          buf_d      = WDATA;
          word_bit_d = '0;
          // last word is truncated to what the chain still needs
          word_len_d = (remaining < 32'(WORD_W)) ? WBW'(remaining) : WBW'(WORD_W);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        buf_d       = buf_q >> 1;
        bits_sent_d = bits_sent_q + 1'b1;
        word_bit_d  = word_bit_q + 1'b1;
        if (word_bit_d == word_len_q) begin
          state_d = (bits_sent_d == BW'(CHAIN_LEN)) ? ST_UPDATE : ST_LOAD;
        end
      end
      ST_UPDATE: state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    WREADY = 1'b0;
    SEN    = 1'b0;
    SDO    = 1'b0;
    UPD    = 1'b0;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        WREADY = 1'b1;
        BUSY   = 1'b1;
      end
      ST_SHIFT: begin
        SEN  = 1'b1;
        SDO  = buf_q[0];
        BUSY = 1'b1;
      end
      ST_UPDATE: begin
        UPD  = 1'b1;
        BUSY = 1'b1;
      end
      ST_FINISH: DONE = 1'b1;
      default: ;
    endcase
  end

`ifdef DFF_CHAIN_READBACK_EN
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == ST_IDLE && START) begin
      rdata_d = '0;
    end else if (state_q == ST_SHIFT) begin
      rdata_d                = rdata_q >> 1;
      rdata_d[CHAIN_LEN-1]   = SDI;
    end
  end

  assign RDATA  = rdata_q;
  assign RVALID = (state_q == ST_FINISH);
`endif

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Bench for dff_chain_ctrl: one 16-cell and one 10-cell instance, table rows, corner sequences, random runs.
module tb_dff_chain_ctrl;

`ifdef DFF_CHAIN_READBACK_EN
  localparam int OW = 7;
`else
  localparam int OW = 6;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      start, wvalid;
  logic [1:0][7:0] wdata;
  logic [1:0]      wready, sen, sdo, upd, busy, done;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

`ifdef DFF_CHAIN_READBACK_EN
  logic [1:0]  sdi, rvalid;
  logic [15:0] rdata16, chain16, pre_val;
  logic [9:0]  rdata10, chain10;
  logic        pre_req;

  always @(posedge clk) begin
    if (pre_req) begin
      chain16 <= pre_val;
      chain10 <= '0;
    end else begin
      if (sen[0]) chain16 <= {sdo[0], chain16[15:1]};
      if (sen[1]) chain10 <= {sdo[1], chain10[9:1]};
    end
  end
  assign sdi = {chain10[0], chain16[0]};
`endif

  dff_chain_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .CLK(clk), .RST(rst), .START(start[0]), .WDATA(wdata[0]), .WVALID(wvalid[0]),
    .WREADY(wready[0]), .SDO(sdo[0]), .SEN(sen[0]), .UPD(upd[0]), .BUSY(busy[0]), .DONE(done[0])
`ifdef DFF_CHAIN_READBACK_EN
    , .SDI(sdi[0]), .RDATA(rdata16), .RVALID(rvalid[0])
`endif
  );

  dff_chain_ctrl #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
    .CLK(clk), .RST(rst), .START(start[1]), .WDATA(wdata[1]), .WVALID(wvalid[1]),
    .WREADY(wready[1]), .SDO(sdo[1]), .SEN(sen[1]), .UPD(upd[1]), .BUSY(busy[1]), .DONE(done[1])
`ifdef DFF_CHAIN_READBACK_EN
    , .SDI(sdi[1]), .RDATA(rdata10), .RVALID(rvalid[1])
`endif
  );

  function automatic logic [OW-1:0] obs(input int d);
`ifdef DFF_CHAIN_READBACK_EN
    return {wready[d], sen[d], sdo[d], upd[d], busy[d], done[d], rvalid[d]};
`else
    return {wready[d], sen[d], sdo[d], upd[d], busy[d], done[d]};
`endif
  endfunction

  function automatic logic [OW-1:0] mk(input logic wr, sn, sd, up, bs, dn);
`ifdef DFF_CHAIN_READBACK_EN
    return {wr, sn, sd, up, bs, dn, dn};
`else
    return {wr, sn, sd, up, bs, dn};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Expected per-cycle outputs are built from the word/gap schedule, then the DUT is stepped through it.
  task automatic run_seq(input int d, input logic [7:0] w0, input logic [7:0] w1,
                         input int g0, input int g1, input bit noise,
                         output logic [31:0] sdo_bits, output int sen_cnt, output int upd_c,
                         output int done_c, output int upd_n, output int done_n,
                         output logic [15:0] rd_done);
    logic [OW-1:0] exp_q[$];
    logic [8:0]    drv_q[$];
    logic [7:0]    w[2];
    int            g[2];
    int            rem;
    int            len;
    logic [OW-1:0] got;
    w[0] = w0; w[1] = w1; g[0] = g0; g[1] = g1;
    rem = (d != 0) ? 10 : 16;
    for (int k = 0; k < 2 && rem > 0; k++) begin
      len = (rem < 8) ? rem : 8;
      for (int i = 0; i < g[k]; i++) begin
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0));
        drv_q.push_back({1'b0, 8'($urandom)});
      end
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0));
      drv_q.push_back({1'b1, w[k]});
      for (int b = 0; b < len; b++) begin
        exp_q.push_back(mk(0, 1, w[k][b], 0, 1, 0));
        drv_q.push_back(noise ? 9'($urandom) : 9'h0);
      end
      rem -= len;
    end
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (3) drv_q.push_back(noise ? 9'($urandom) : 9'h0);

    sdo_bits = '0; sen_cnt = 0; upd_c = -1; done_c = -1; upd_n = 0; done_n = 0; rd_done = '0;
    @(negedge clk);
    start[d] = 1'b1; wvalid[d] = 1'b0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      got = obs(d);
      chk($sformatf("trace d=%0d c=%0d", d, c), 32'(got), 32'(exp_q[c-1]));
      if (sen[d] === 1'b1 && sen_cnt < 32) begin
        sdo_bits[sen_cnt] = sdo[d];
        sen_cnt++;
      end
      if (upd[d] === 1'b1) begin upd_n++; upd_c = c; end
      if (done[d] === 1'b1) begin
        done_n++; done_c = c;
`ifdef DFF_CHAIN_READBACK_EN
        if (d == 0) rd_done = rdata16;
`endif
      end
      wvalid[d] = drv_q[c-1][8];
      wdata[d]  = drv_q[c-1][7:0];
      start[d]  = noise && (c < exp_q.size());
    end
    start[d] = 1'b0; wvalid[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic [7:0]  w0, w1;
    int          gap1;
    bit          noise;
    logic [31:0] exp_sdo;
    int          exp_sen, exp_upd, exp_done;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] bits, mask;
  int          nsen, uc, dc, un, dn;
  logic [15:0] rd;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 8'hA5, 8'h3C, 0, 0, 32'h3CA5, 16, 19, 20};
    tbl[1] = '{0, 8'hA5, 8'h3C, 5, 0, 32'h3CA5, 16, 24, 25};
    tbl[2] = '{1, 8'hFF, 8'hFE, 0, 0, 32'h2FF, 10, 13, 14};
    tbl[3] = '{1, 8'hFF, 8'hFE, 3, 1, 32'h2FF, 10, 16, 17};
    tbl[4] = '{0, 8'h5A, 8'hC3, 2, 1, 32'hC35A, 16, 21, 22};

    rst = 1'b1; start = '0; wvalid = '0; wdata = '0;
`ifdef DFF_CHAIN_READBACK_EN
    pre_req = 1'b1; pre_val = 16'h1234;
`endif
    repeat (3) @(negedge clk);
    chk("reset16", 32'(obs(0)), 32'h0);
    chk("reset10", 32'(obs(1)), 32'h0);
`ifdef DFF_CHAIN_READBACK_EN
    chk("reset_rdata", 32'(rdata16), 32'h0);
    pre_req = 1'b0;
`endif
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_seq(tbl[i].d, tbl[i].w0, tbl[i].w1, 0, tbl[i].gap1, tbl[i].noise,
              bits, nsen, uc, dc, un, dn, rd);
      mask = (tbl[i].d != 0) ? 32'h3FF : 32'hFFFF;
      chk($sformatf("tbl%0d sdo", i), bits & mask, tbl[i].exp_sdo);
      chk($sformatf("tbl%0d sen", i), 32'(nsen), 32'(tbl[i].exp_sen));
      chk($sformatf("tbl%0d upd_at", i), 32'(uc), 32'(tbl[i].exp_upd));
      chk($sformatf("tbl%0d done_at", i), 32'(dc), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d upd_n", i), 32'(un), 32'd1);
      chk($sformatf("tbl%0d done_n", i), 32'(dn), 32'd1);
`ifdef DFF_CHAIN_READBACK_EN
      if (i == 0) begin
        chk("readback_rdata", 32'(rd), 32'h1234);
        chk("readback_chain", 32'(chain16), 32'h3CA5);
      end
`endif
    end

    // reset on the 4th shift cycle
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; wvalid[0] = 1'b1; wdata[0] = 8'hA5;
    repeat (3) @(negedge clk);
    wvalid[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_sen", 32'(sen[0]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", 32'(obs(0)), 32'h0);
`ifdef DFF_CHAIN_READBACK_EN
    chk("rst_rdata", 32'(rdata16), 32'h0);
`endif
    wvalid[0] = 1'b1; wdata[0] = 8'hFF;
    @(negedge clk);
    chk("rst_idle_hold", 32'(obs(0)), 32'h0);
    wvalid[0] = 1'b0;
    run_seq(0, 8'h01, 8'h00, 0, 0, 1'b0, bits, nsen, uc, dc, un, dn, rd);
    chk("post_rst sdo", bits & 32'hFFFF, 32'h0001);
    chk("post_rst upd_at", 32'(uc), 32'd19);
    chk("post_rst done_n", 32'(dn), 32'd1);

    for (int r = 0; r < 24; r++) begin
      int          d;
      logic [7:0]  a, b;
      d = int'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom);
      wvalid[d] = 1'($urandom); wdata[d] = 8'($urandom);
      @(negedge clk);
      chk($sformatf("rnd%0d idle", r), 32'(obs(d)), 32'h0);
      wvalid[d] = 1'b0;
      run_seq(d, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom), bits, nsen, uc, dc, un, dn, rd);
      chk($sformatf("rnd%0d upd_n", r), 32'(un), 32'd1);
      chk($sformatf("rnd%0d sdo", r), bits & ((d != 0) ? 32'h3FF : 32'hFFFF),
          (d != 0) ? 32'({b[1:0], a}) : 32'({b, a}));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
